// File: rtl/sccpu_pkg.sv
// Shared types and constants for the single-cycle CPU instruction front end.
package sccpu_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } imem_ld_state_t;

    localparam logic [31:0] SCCPU_NOP = 32'h0000_0000;

endpackage

// File: rtl/sccpu_imem_ram.sv
// DEPTH x 32 instruction storage: synchronous write, asynchronous read.
module sccpu_imem_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sccpu_imem_loader.sv
// Clears the instruction RAM, loads a little-endian byte stream into it,
// then releases the CPU and serves inst combinationally from pc.
module sccpu_imem_loader
    import sccpu_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              cpu_clrn,
    output logic              load_done,
    output logic [ADDR_W:0]   load_words,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0]   FULL_ADDR = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    imem_ld_state_t    state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [ADDR_W:0]   word_addr_q, word_addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       shreg_q, shreg_d;
    logic              err_q, err_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       asm_word;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            word_addr_q <= '0;
            lane_q      <= '0;
            shreg_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            word_addr_q <= word_addr_d;
            lane_q      <= lane_d;
            shreg_q     <= shreg_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        word_addr_d = word_addr_q;
        lane_d      = lane_q;
        shreg_d     = shreg_q;
        err_d       = err_q;
        ram_we      = 1'b0;
        ram_waddr   = clr_idx_q;
        ram_wdata   = SCCPU_NOP;
        // Unfilled upper lanes of shreg are always 0, so this is also the padded partial word.
        asm_word    = {8'h00, shreg_q};
        asm_word[{lane_q, 3'b000} +: 8] = ld_byte;

        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_idx_q;
                ram_wdata = SCCPU_NOP;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) state_d = LOAD;
            end
            LOAD: begin
                if (ld_valid) begin
                    if (word_addr_q == FULL_ADDR) begin
                        err_d = 1'b1;
                    end else if (lane_q == 2'd3 || ld_last) begin
                        ram_we      = 1'b1;
                        ram_waddr   = word_addr_q[ADDR_W-1:0];
                        ram_wdata   = asm_word;
                        word_addr_d = word_addr_q + 1'b1;
                        lane_d      = '0;
                        shreg_d     = '0;
                    end else begin
                        lane_d  = lane_q + 1'b1;
                        shreg_d = asm_word[23:0];
                    end
                    if (ld_last) state_d = RUN;
                end
            end
            RUN: ;
            default: state_d = CLEAR;
        endcase
    end

    sccpu_imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    logic pc_unused;
    assign pc_unused = ^pc[1:0];

    assign ld_ready     = (state_q == LOAD);
    assign cpu_clrn     = (state_q == RUN);
    assign load_done    = (state_q == RUN);
    assign load_words   = word_addr_q;
    assign err_overflow = err_q;
    assign inst         = (state_q == RUN && pc[31:ADDR_W+2] == '0) ? ram_rdata : SCCPU_NOP;

endmodule

// File: tb/tb_sccpu_imem_loader.sv
// Randomized bench for sccpu_imem_loader against a byte-queue reference model.
module tb_sccpu_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        ld_ready, cpu_clrn, load_done, err_overflow;
    logic [31:0] inst;
    logic [AW:0] load_words;

    int checks = 0;
    int errors = 0;
    logic [7:0] prog[$];

    sccpu_imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .pc           (pc),
        .inst         (inst),
        .cpu_clrn     (cpu_clrn),
        .load_done    (load_done),
        .load_words   (load_words),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk("async_rst_ready", {31'h0, ld_ready}, 32'h0);
        chk("async_rst_cpuclrn", {31'h0, cpu_clrn}, 32'h0);
        chk("async_rst_words", 32'(load_words), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        pc = $urandom;
        chk("rst_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_done", {31'h0, load_done}, 32'h0);
        chk("rst_err", {31'h0, err_overflow}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        clrn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("clear_ready", {31'h0, ld_ready}, 32'h0);
            chk("clear_cpuclrn", {31'h0, cpu_clrn}, 32'h0);
            chk("clear_inst", inst, 32'h0);
        end
        @(negedge clk);
        chk("clear_end_ready", {31'h0, ld_ready}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int maxgap);
        int gaps;
        gaps = $urandom_range(maxgap, 0);
        repeat (gaps) begin
            ld_valid = 1'b0;
            ld_byte  = 8'($urandom);
            ld_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        pc = $urandom;
        @(negedge clk);
        chk("load_ready", {31'h0, ld_ready}, 32'h1);
        chk("load_inst", inst, 32'h0);
        if (last) chk("pre_last_cpuclrn", {31'h0, cpu_clrn}, 32'h0);
        @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0;
        if (last) begin
            chk("post_last_ready", {31'h0, ld_ready}, 32'h0);
            chk("post_last_cpuclrn", {31'h0, cpu_clrn}, 32'h1);
            chk("post_last_done", {31'h0, load_done}, 32'h1);
        end
    endtask

    task automatic load_prog(input int maxgap, input logic with_last);
        for (int i = 0; i < prog.size(); i++)
            send_byte(prog[i], with_last && (i == prog.size() - 1), maxgap);
    endtask

    // Word w of RAM is bytes 4w..4w+3 of the program, little-endian, zero where absent.
    function automatic logic [31:0] model_word(input int w);
        logic [31:0] r;
        r = 32'h0;
        if (w < DEPTH)
            for (int k = 0; k < 4; k++)
                if (4 * w + k < prog.size()) r[8*k +: 8] = prog[4*w + k];
        return r;
    endfunction

    task automatic check_run();
        int n, nw;
        n  = prog.size();
        nw = (n + 3) / 4;
        if (nw > DEPTH) nw = DEPTH;
        chk("run_words", 32'(load_words), 32'(nw));
        chk("run_err", {31'h0, err_overflow}, {31'h0, n > 4 * DEPTH});
        chk("run_done", {31'h0, load_done}, 32'h1);
        chk("run_cpuclrn", {31'h0, cpu_clrn}, 32'h1);
        chk("run_ready", {31'h0, ld_ready}, 32'h0);
        for (int w = 0; w < DEPTH; w++) begin
            pc = 32'(4 * w) + 32'($urandom_range(3, 0));
            #1;
            chk($sformatf("run_inst[%0d]", w), inst, model_word(w));
        end
        pc = 32'h104;
        #1;
        chk("oor_inst_104", inst, 32'h0);
        pc = $urandom | 32'h100;
        #1;
        chk("oor_inst_rand", inst, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        prog = '{8'h05, 8'h00, 8'h03, 8'h14, 8'h00, 8'h00, 8'h09, 8'h14};
        load_prog(0, 1'b1);
        check_run();
        pc = 32'h0; #1; chk("t1_pc0", inst, 32'h1403_0005);
        pc = 32'h4; #1; chk("t1_pc4", inst, 32'h1409_0000);
        pc = 32'h8; #1; chk("t1_pc8", inst, 32'h0);

        do_reset();
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_prog(2, 1'b1);
        check_run();
        pc = 32'h4; #1; chk("t2_word1", inst, 32'h0000_2211);
        pc = 32'h0; #1; chk("t2_word0", inst, 32'hDDCC_BBAA);

        repeat (4) begin
            do_reset();
            prog = {};
            repeat ($urandom_range(40, 1)) prog.push_back(8'($urandom));
            load_prog(3, 1'b1);
            check_run();
        end

        do_reset();
        prog = {};
        repeat (4 * 65 + 1) prog.push_back(8'($urandom));
        load_prog(0, 1'b1);
        check_run();

        do_reset();
        prog = {};
        repeat (12) prog.push_back(8'($urandom));
        load_prog(1, 1'b0);
        chk("midload_words", 32'(load_words), 32'd3);
        prog = {};
        repeat (4) prog.push_back(8'($urandom));
        do_reset();
        load_prog(1, 1'b1);
        check_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
